// File: rtl/shift_divider.sv
// shift_divider: restoring shift-subtract divider, one quotient bit per clock.
// Ports: clk, rst_n, start, dividend, divisor -> busy, done, quotient, remainder
// (+ dbz when DIVIDER_DBZ_FLAG_EN is defined).
module shift_divider #(
   parameter int size = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [size-1:0] dividend,
   input  logic [size-1:0] divisor,
   output logic            busy,
   output logic            done,
   output logic [size-1:0] quotient,
   output logic [size-1:0] remainder
`ifdef DIVIDER_DBZ_FLAG_EN
   ,
   output logic            dbz
`endif
);

   localparam int CW = $clog2(size + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state, state_nxt;
   logic [size-1:0] dq, dvs, pr;
   logic [CW-1:0]   count;
   logic            load, last;

   logic [size:0]   shf;
   logic            ge;
   logic [size-1:0] diff, pr_nxt, dq_nxt;

   // Restoring step; the difference fits in size bits because
   // it is only kept when it is below the divisor.
   assign shf    = {pr, dq[size-1]};
   assign ge     = shf >= {1'b0, dvs};
   assign diff   = shf[size-1:0] - dvs;
   assign pr_nxt = ge ? diff : shf[size-1:0];
   assign dq_nxt = {dq[size-2:0], ge};

   assign busy = (state == RUN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      last      = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            if (count == CW'(1)) begin
               state_nxt = IDLE;
               last      = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dq        <= '0;
         dvs       <= '0;
         pr        <= '0;
         count     <= '0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIVIDER_DBZ_FLAG_EN
         dbz       <= 1'b0;
`endif
      end else begin
         done <= last;
         if (load) begin
            dq    <= dividend;
            dvs   <= divisor;
            pr    <= '0;
            count <= CW'(size);
         end else if (state == RUN) begin
            dq    <= dq_nxt;
            pr    <= pr_nxt;
            count <= count - CW'(1);
         end
         if (last) begin
            remainder <= pr_nxt;
`ifdef DIVIDER_DBZ_FLAG_EN
            quotient  <= (dvs == '0) ? '0 : dq_nxt;
            dbz       <= (dvs == '0);
`else
            quotient  <= dq_nxt;
`endif
         end
      end
   end

endmodule
